// File: rtl/ct_spsram_init_param_if.sv
// Access bus of the parametrised single-port SRAM wrapper.
// The controller side uses the master modport and the SRAM wrapper uses the slave modport.
interface ct_spsram_init_param_if #(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned DATA_WIDTH = 7,
   parameter int unsigned WE_WIDTH   = 7
);
   logic [ADDR_WIDTH-1:0] A;
   logic                  CEN;
   logic                  GWEN;
   logic [WE_WIDTH-1:0]   WEN;
   logic [DATA_WIDTH-1:0] D;
   logic [DATA_WIDTH-1:0] Q;
   logic                  init_req;
   logic                  init_busy;
   logic                  init_done;

   modport master (
      output A, CEN, GWEN, WEN, D, init_req,
      input  Q, init_busy, init_done
   );

   modport slave (
      input  A, CEN, GWEN, WEN, D, init_req,
      output Q, init_busy, init_done
   );
endinterface

// File: rtl/ct_spsram_init_param.sv
// Parametrised single-port SRAM with lane write enables and an optional output register.
// A clear engine writes INIT_VAL to every entry after reset or on init_req.
module ct_spsram_init_param #(
   parameter int unsigned           ADDR_WIDTH = 9,
   parameter int unsigned           DATA_WIDTH = 7,
   parameter int unsigned           WE_WIDTH   = 7,
   parameter int unsigned           OUT_REG    = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
   input logic                     CLK,
   input logic                     cpurst_b,
   ct_spsram_init_param_if.slave   sram_if
);

   localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
   localparam int unsigned LANE_W = DATA_WIDTH / WE_WIDTH;

   if ((DATA_WIDTH % WE_WIDTH) != 0) begin : g_bad_lanes
      $fatal(1, "DATA_WIDTH must be a multiple of WE_WIDTH");
   end

   typedef enum logic [0:0] {StInit, StReady} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  busy;
   logic                  rd_en;
   logic [WE_WIDTH-1:0]   lane_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // State register
   always_ff @(posedge CLK or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q   <= StInit;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      unique case (state_q)
         StInit: begin
            // init_req is ignored here, so a sweep is never restarted or extended.
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == '1) begin
               state_d = StReady;
               done_d  = 1'b1;
            end
         end
         StReady: begin
            if (sram_if.init_req) begin
               state_d = StInit;
               cnt_d   = '0;
               done_d  = 1'b0;
            end
         end
         default: state_d = StInit;
      endcase
   end

   // Output / array control logic
   always_comb begin
      busy      = (state_q == StInit);
      rd_en     = 1'b0;
      lane_we   = '0;
      mem_addr  = sram_if.A;
      mem_wdata = sram_if.D;
      if (busy) begin
         lane_we   = '1;
         mem_addr  = cnt_q;
         mem_wdata = INIT_VAL;
      end else if (!sram_if.CEN) begin
         if (sram_if.GWEN) begin
            rd_en = 1'b1;
         end else begin
            lane_we = ~sram_if.WEN;
         end
      end
      rd_data_d = rd_en ? mem_q[sram_if.A] : rd_data_q;
   end

   // Array contents are deliberately left without reset.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < int'(WE_WIDTH); i++) begin
         if (lane_we[i]) begin
            mem_q[mem_addr][i*LANE_W +: LANE_W] <= mem_wdata[i*LANE_W +: LANE_W];
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q_q;
      always_ff @(posedge CLK or negedge cpurst_b) begin
         if (!cpurst_b) begin
            q_q <= '0;
         end else begin
            q_q <= rd_data_q;
         end
      end
      assign sram_if.Q = q_q;
   end else begin : g_no_out_reg
      assign sram_if.Q = rd_data_q;
   end

   assign sram_if.init_busy = busy;
   assign sram_if.init_done = done_q;

endmodule

// File: tb/tb_ct_spsram_init_param.sv
// Bench for ct_spsram_init_param: a 512x7 default instance and a 64x32 registered-output variant.
// Reads push expected data into per-instance queues; negedge monitors pop and compare.
module tb_ct_spsram_init_param;

   logic CLK = 1'b0;
   logic rst0_n = 1'b1;
   logic rst1_n = 1'b1;

   always #5 CLK = ~CLK;

   ct_spsram_init_param_if #(.ADDR_WIDTH(9), .DATA_WIDTH(7), .WE_WIDTH(7)) b0 ();
   ct_spsram_init_param_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .WE_WIDTH(4)) b1 ();

   ct_spsram_init_param #(
      .ADDR_WIDTH(9), .DATA_WIDTH(7), .WE_WIDTH(7), .OUT_REG(0), .INIT_VAL(7'h00)
   ) u_dut0 (
      .CLK      (CLK),
      .cpurst_b (rst0_n),
      .sram_if  (b0)
   );

   ct_spsram_init_param #(
      .ADDR_WIDTH(6), .DATA_WIDTH(32), .WE_WIDTH(4), .OUT_REG(1), .INIT_VAL(32'hDEADBEEF)
   ) u_dut1 (
      .CLK      (CLK),
      .cpurst_b (rst1_n),
      .sram_if  (b1)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];
   logic        iss0 = 1'b0;
   logic        iss1 = 1'b0;
   logic        pipe0 = 1'b0;
   logic [1:0]  pipe1 = 2'b00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Default instance: read data valid one cycle after the access.
   always @(negedge CLK) begin
      if (pipe0) begin
         if (exp_q0.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb0 read: got %h, expected no data", b0.Q);
         end else begin
            check("sb0 read", 32'(b0.Q), exp_q0.pop_front());
         end
      end
      pipe0 = iss0;
   end

   // Registered-output variant: read data valid two cycles after the access.
   always @(negedge CLK) begin
      if (pipe1[1]) begin
         if (exp_q1.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb1 read: got %h, expected no data", b1.Q);
         end else begin
            check("sb1 read", b1.Q, exp_q1.pop_front());
         end
      end
      pipe1 = {pipe1[0], iss1};
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle0();
      b0.A = '0; b0.CEN = 1'b1; b0.GWEN = 1'b1; b0.WEN = '1; b0.D = '0; b0.init_req = 1'b0;
      iss0 = 1'b0;
   endtask

   task automatic idle1();
      b1.A = '0; b1.CEN = 1'b1; b1.GWEN = 1'b1; b1.WEN = '1; b1.D = '0; b1.init_req = 1'b0;
      iss1 = 1'b0;
   endtask

   task automatic rd0(input logic [8:0] a, input logic [6:0] exp);
      b0.A = a; b0.CEN = 1'b0; b0.GWEN = 1'b1; iss0 = 1'b1;
      exp_q0.push_back(32'(exp));
      tick();
      idle0();
   endtask

   task automatic wr0(input logic [8:0] a, input logic [6:0] d, input logic [6:0] wen);
      b0.A = a; b0.D = d; b0.WEN = wen; b0.CEN = 1'b0; b0.GWEN = 1'b0;
      tick();
      idle0();
   endtask

   task automatic rd1(input logic [5:0] a, input logic [31:0] exp);
      b1.A = a; b1.CEN = 1'b0; b1.GWEN = 1'b1; iss1 = 1'b1;
      exp_q1.push_back(exp);
      tick();
      idle1();
   endtask

   task automatic wr1(input logic [5:0] a, input logic [31:0] d, input logic [3:0] wen);
      b1.A = a; b1.D = d; b1.WEN = wen; b1.CEN = 1'b0; b1.GWEN = 1'b0;
      tick();
      idle1();
   endtask

   initial begin
      int   n;
      logic qbad;
      idle0();
      idle1();
      #2;
      rst0_n = 1'b0;
      rst1_n = 1'b0;
      repeat (3) tick();

      check("rst Q", 32'(b0.Q), 32'h0);
      check("rst busy", 32'(b0.init_busy), 32'h1);
      check("rst done", 32'(b0.init_done), 32'h0);
      check("v rst Q", b1.Q, 32'h0);
      check("v rst busy", 32'(b1.init_busy), 32'h1);

      // Initial sweep, with a write attempted during the clear.
      rst0_n = 1'b1;
      n = 0;
      while (b0.init_busy && n < 2000) begin
         if (n == 10) begin
            b0.A = 9'd3; b0.D = 7'h55; b0.CEN = 1'b0; b0.GWEN = 1'b0; b0.WEN = '0;
         end else begin
            idle0();
         end
         tick();
         n++;
      end
      idle0();
      check("sweep len", 32'(n), 32'd512);
      check("done after sweep", 32'(b0.init_done), 32'h1);
      rd0(9'd0, 7'h00);
      rd0(9'd255, 7'h00);
      rd0(9'd511, 7'h00);
      rd0(9'd3, 7'h00);

      // Lane writes: lanes 1 and 3 cleared out of 7'h7F.
      wr0(9'h1A5, 7'h7F, 7'b0000000);
      wr0(9'h1A5, 7'h00, 7'b1110101);
      rd0(9'h1A5, 7'h75);

      // Read-after-write, and a write must not disturb Q.
      wr0(9'd8, 7'h5A, 7'b0000000);
      rd0(9'd8, 7'h5A);
      wr0(9'd9, 7'h11, 7'b0000000);
      check("Q hold on write", 32'(b0.Q), 32'h5A);

      // Unknown address/data with CEN high, then a write with every lane disabled.
      b0.A = 'x; b0.D = 'x; b0.CEN = 1'b1; b0.GWEN = 1'b0; b0.WEN = '0;
      tick();
      idle0();
      wr0(9'd8, 7'h00, 7'b1111111);
      rd0(9'd8, 7'h5A);
      rd0(9'd9, 7'h11);
      rd0(9'h1A5, 7'h75);

      // Re-clear requested together with a read of address 7.
      wr0(9'd7, 7'h2A, 7'b0000000);
      b0.A = 9'd7; b0.CEN = 1'b0; b0.GWEN = 1'b1; b0.init_req = 1'b1; iss0 = 1'b1;
      exp_q0.push_back(32'h2A);
      tick();
      idle0();
      check("reclear done low", 32'(b0.init_done), 32'h0);
      check("reclear busy", 32'(b0.init_busy), 32'h1);
      n = 0;
      qbad = 1'b0;
      while (b0.init_busy && n < 2000) begin
         b0.init_req = (n == 100);
         if (b0.Q !== 7'h2A) qbad = 1'b1;
         tick();
         n++;
      end
      idle0();
      check("reclear len", 32'(n), 32'd512);
      check("Q held in sweep", 32'(qbad), 32'h0);
      check("reclear done", 32'(b0.init_done), 32'h1);
      rd0(9'd7, 7'h00);

      // Reset asserted partway through a sweep.
      wr0(9'd5, 7'h33, 7'b0000000);
      rd0(9'd5, 7'h33);
      b0.init_req = 1'b1;
      tick();
      idle0();
      repeat (300) tick();
      rst0_n = 1'b0;
      #1;
      check("midrst Q", 32'(b0.Q), 32'h0);
      check("midrst done", 32'(b0.init_done), 32'h0);
      check("midrst busy", 32'(b0.init_busy), 32'h1);
      tick();
      rst0_n = 1'b1;
      n = 0;
      while (b0.init_busy && n < 2000) begin
         tick();
         n++;
      end
      check("post-rst sweep len", 32'(n), 32'd512);
      check("post-rst done", 32'(b0.init_done), 32'h1);
      rd0(9'd5, 7'h00);

      // Registered-output variant.
      rst1_n = 1'b1;
      n = 0;
      while (b1.init_busy && n < 2000) begin
         tick();
         n++;
      end
      check("v sweep len", 32'(n), 32'd64);
      check("v done", 32'(b1.init_done), 32'h1);
      rd1(6'd10, 32'hDEADBEEF);
      check("v Q latency", b1.Q, 32'h0);
      wr1(6'd20, 32'h11223344, 4'b1010);
      rd1(6'd20, 32'hDE22BE44);

      repeat (4) tick();
      check("sb0 drained", 32'(exp_q0.size()), 32'd0);
      check("sb1 drained", 32'(exp_q1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
